// File: rtl/message_packer.sv
// Purpose: packs 16 x 32-bit words into one 512-bit block; the first word accepted lands in [511:480].
// Latency: block_valid rises the cycle after the edge that accepts the 16th word; sustains one word/cycle.
// Backpressure: word_ready drops only at cnt==15 while the output register is full and not draining.
//
// Ports:
//   clk, rst                  single clock, asynchronous active-high reset
//   word_in/_valid/_ready     32-bit word input handshake
//   block_out/_valid/_ready   512-bit block output handshake
//   word_count                words held in the assembly register (0..15)
module message_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  word_in,
    input  logic         word_valid,
    output logic         word_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    input  logic         block_ready,
    output logic [3:0]   word_count
);

    logic [511:0] asm_q;
    logic [3:0]   cnt_q;
    logic         accept;
    logic         completing;
    logic         drain;

    // Only the completing word can stall: words 1..15 go into asm, which is
    // independent of the output register, so they never need to wait.
    always_comb begin
        word_ready = 1'b1;
        if (cnt_q == 4'd15 && block_valid && !block_ready) begin
            word_ready = 1'b0;
        end
    end

    assign accept     = word_valid && word_ready;
    assign completing = accept && (cnt_q == 4'd15);
    assign drain      = block_valid && block_ready;
    assign word_count = cnt_q;

    // Assembly register: shift left so the oldest word ends up in the top slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= '0;
            cnt_q <= 4'd0;
        end else if (accept) begin
            asm_q <= {asm_q[479:0], word_in};
            cnt_q <= (cnt_q == 4'd15) ? 4'd0 : cnt_q + 4'd1;
        end
    end

    // Output register: a completing accept wins over a drain in the same
    // cycle, which is what gives gapless back-to-back blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_out   <= '0;
            block_valid <= 1'b0;
        end else if (completing) begin
            block_out   <= {asm_q[479:0], word_in};
            block_valid <= 1'b1;
        end else if (drain) begin
            block_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_message_packer.sv
module tb_message_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  word_in = '0;
    logic         word_valid = 1'b0;
    logic         word_ready;
    logic [511:0] block_out;
    logic         block_valid;
    logic         block_ready = 1'b0;
    logic [3:0]   word_count;

    int n_chk  = 0;
    int n_pass = 0;
    bit run    = 1'b0;
    bit rdy_s  = 1'b0;

    message_packer dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .block_out  (block_out),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h want %08h", nm, act, exp);
    endtask

    task automatic chk512(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Holds the accepted words of the current block as a list; a block is
    // built by laying the list out top-down once it reaches 16 entries.
    logic [31:0]  m_words[$];
    logic [511:0] m_block = '0;
    bit           m_valid = 1'b0;
    bit           m_acc;
    bit           m_drn;

    function automatic bit m_ready();
        return !(m_words.size() == 15 && m_valid && !block_ready);
    endfunction

    function automatic logic [511:0] m_pack();
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = m_words[i];
        return b;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_words.delete();
            m_block = '0;
            m_valid = 1'b0;
        end else begin
            m_acc = word_valid && m_ready();
            m_drn = m_valid && block_ready;
            if (m_drn) m_valid = 1'b0;
            if (m_acc) begin
                m_words.push_back(word_in);
                if (m_words.size() == 16) begin
                    m_block = m_pack();
                    m_valid = 1'b1;
                    m_words.delete();
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            chk32("model_word_ready", 32'(word_ready), 32'(m_ready()));
            chk32("model_word_count", 32'(word_count), m_words.size());
            chk32("model_block_valid", 32'(block_valid), 32'(m_valid));
            chk512("model_block_out", block_out, m_block);
        end
    end

    // One clock: sample word_ready before the edge, return 1 time unit after it.
    task automatic cyc();
        @(negedge clk);
        rdy_s = word_ready;
        @(posedge clk);
        #1;
    endtask

    int cycles;
    int acc_n;
    int drops;
    int t_v[$];

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;
        chk32("rst_word_count", 32'(word_count), 32'd0);
        chk32("rst_block_valid", 32'(block_valid), 32'd0);
        chk512("rst_block_out", block_out, 512'd0);
        chk32("rst_word_ready", 32'(word_ready), 32'd1);

        // ---------------- 1: basic fill ----------------
        block_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            word_valid = 1'b1;
            word_in    = 32'(i);
            chk32("s1_count_seq", 32'(word_count), 32'(i));
            cyc();
        end
        word_valid = 1'b0;
        chk32("s1_valid", 32'(block_valid), 32'd1);
        chk32("s1_top", block_out[511:480], 32'h0000_0000);
        chk32("s1_bot", block_out[31:0], 32'h0000_000F);
        chk32("s1_count_wrap", 32'(word_count), 32'd0);

        // ---------------- 2: gapped input ----------------
        cycles = 0;
        while (!block_valid || cycles == 0) begin
            if (cycles >= 100) begin
                chk32("s2_timeout", 32'(cycles), 32'd31);
                break;
            end
            word_valid = (cycles % 2 == 0);
            word_in    = 32'(cycles / 2);
            if (cycles % 2 == 1) chk32("s2_gap_hold", 32'(word_count), 32'((cycles + 1) / 2));
            cyc();
            cycles++;
        end
        word_valid = 1'b0;
        chk32("s2_latency", 32'(cycles), 32'd31);
        chk32("s2_top", block_out[511:480], 32'h0000_0000);
        chk32("s2_bot", block_out[31:0], 32'h0000_000F);
        cyc();  // drain the gapped block

        // ---------------- 3: backpressure ----------------
        block_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            word_valid = 1'b1;
            word_in    = 32'hA000_0000 + 32'(i);
            cyc();
        end
        acc_n = 0;
        for (int k = 0; k < 20; k++) begin
            word_valid = 1'b1;
            word_in    = 32'hB000_0000 + 32'(acc_n);
            cyc();
            if (rdy_s) acc_n++;
        end
        chk32("s3_b_accepted", 32'(acc_n), 32'd15);
        chk32("s3_ready_low", 32'(word_ready), 32'd0);
        chk32("s3_count15", 32'(word_count), 32'd15);
        chk32("s3_hold_a_top", block_out[511:480], 32'hA000_0000);
        chk32("s3_hold_a_bot", block_out[31:0], 32'hA000_000F);
        block_ready = 1'b1;
        word_in     = 32'hB000_000F;
        #1;
        chk32("s3_ready_comb", 32'(word_ready), 32'd1);
        cyc();
        block_ready = 1'b0;
        word_valid  = 1'b0;
        chk32("s3_valid_stays", 32'(block_valid), 32'd1);
        chk32("s3_b_bot", block_out[31:0], 32'hB000_000F);
        chk32("s3_b_top", block_out[511:480], 32'hB000_0000);
        chk32("s3_count0", 32'(word_count), 32'd0);

        // ---------------- 4: drain only ----------------
        for (int i = 0; i < 3; i++) begin
            word_valid = 1'b1;
            word_in    = 32'hC000_0000 + 32'(i);
            cyc();
        end
        word_valid  = 1'b0;
        block_ready = 1'b1;
        cyc();
        block_ready = 1'b0;
        chk32("s4_valid_drop", 32'(block_valid), 32'd0);
        chk32("s4_count_kept", 32'(word_count), 32'd3);
        chk32("s4_out_held", block_out[31:0], 32'hB000_000F);

        // ---------------- 5: reset mid-block ----------------
        for (int i = 3; i < 7; i++) begin
            word_valid = 1'b1;
            word_in    = 32'hC000_0000 + 32'(i);
            cyc();
        end
        word_valid = 1'b0;
        chk32("s5_count7", 32'(word_count), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk32("s5_async_count", 32'(word_count), 32'd0);
        chk32("s5_async_valid", 32'(block_valid), 32'd0);
        chk512("s5_async_out", block_out, 512'd0);
        chk32("s5_async_ready", 32'(word_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        block_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            word_valid = 1'b1;
            word_in    = 32'(i);
            cyc();
        end
        word_valid = 1'b0;
        chk32("s5_valid", 32'(block_valid), 32'd1);
        chk32("s5_top", block_out[511:480], 32'h0000_0001);
        chk32("s5_bot", block_out[31:0], 32'h0000_0010);
        chk32("s5_word7", block_out[287:256], 32'h0000_0008);
        cyc();  // drain

        // ---------------- 6: back-to-back ----------------
        drops = 0;
        for (int c = 0; c < 50; c++) begin
            word_valid = (c < 48);
            word_in    = 32'h0000_0600 + 32'(c);
            cyc();
            if (c < 48 && !rdy_s) drops++;
            if (block_valid) t_v.push_back(c);
        end
        word_valid = 1'b0;
        chk32("s6_no_drop", 32'(drops), 32'd0);
        chk32("s6_blocks", 32'(t_v.size()), 32'd3);
        if (t_v.size() == 3) begin
            chk32("s6_first_at", 32'(t_v[0]), 32'd15);
            chk32("s6_gap1", 32'(t_v[1] - t_v[0]), 32'd16);
            chk32("s6_gap2", 32'(t_v[2] - t_v[1]), 32'd16);
        end
        chk32("s6_last_bot", block_out[31:0], 32'h0000_062F);

        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/message_packer.md
# message_packer

Serial-to-parallel word packer on the message path. It accepts 32-bit words one per cycle over a valid/ready handshake and assembles 16 of them into a 512-bit block. It presents that block to the hashing core over a second valid/ready handshake. Word order is the inverse of the core's word shifter: the first word accepted lands in bits [511:480], and the 16th lands in [31:0].

## Interface

**Parameters**
- None. Widths are fixed: 32-bit words, 16 words per 512-bit block.

**Ports**
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `word_in`  in  32  incoming message word.
- `word_valid`  in  1  `word_in` is valid this cycle.
- `word_ready`  out  1  packer can accept a word this cycle.
- `block_out`  out  512  assembled block; first word in [511:480].
- `block_valid`  out  1  `block_out` holds a complete block.
- `block_ready`  in  1  downstream consumes `block_out` this cycle.
- `word_count`  out  4  words currently held in the assembly register (0..15).

## Operation

**State**
- Assembly register `asm`, 512 bits.
- Word counter `cnt`, 4 bits, equal to `word_count`.
- Output register `block_out` with full flag `block_valid`.

**Handshakes**
- Word accept: `word_valid && word_ready` at a rising edge.
- Block drain: `block_valid && block_ready` at a rising edge.

**Accept with `cnt` < 15**
- `asm <= {asm[479:0], word_in}`.
- `cnt <= cnt + 1`.

**Accept with `cnt` == 15 (completing word)**
- `block_out <= {asm[479:0], word_in}`.
- `block_valid <= 1`.
- `cnt <= 0`; `asm` contents become don't-care.

**`word_ready` rule**
- `word_ready = !(cnt == 15 && block_valid && !block_ready)`.
- This is combinational from `block_ready`.
- A completing word is only accepted if the output register is empty or is being drained in the same cycle.
- Words 1..15 of a block are never stalled by a full output register.

**Output flag update**
- Drain without completing accept: `block_valid <= 0`; `block_out` holds its value.
- Drain and completing accept in the same cycle: `block_valid` stays 1 and `block_out` takes the new block. No bubble, no loss.
- Neither event: `block_out` and `block_valid` hold.

**Other rules**
- `word_in` is ignored when `word_valid` is 0; `asm` and `cnt` hold.
- There is no partial-block flush. A block is emitted only after exactly 16 accepted words.

**Reset (asynchronous, any time including mid-block)**
- `asm` = 0, `cnt` = 0, `block_out` = 0, `block_valid` = 0.
- Partial words are discarded.
- `word_ready` = 1 while and after reset deasserts, since `cnt` = 0.
- The first accept after reset is word 0 of a new block.

## Timing

- Reset values: `block_valid` 0, `block_out` 0, `word_count` 0, `word_ready` 1.
- Latency: `block_valid` rises in the cycle after the edge that accepts the 16th word.
- Throughput: one word per cycle sustained, so one block per 16 cycles. This holds when `block_ready` is high whenever `block_valid` is high, including across block boundaries.
- Backpressure: with the output full and `block_ready` low, the packer absorbs 15 more words. It then holds `word_ready` low at `cnt` = 15 until a drain cycle.
- `block_out` is stable while `block_valid` is 1 and no drain has occurred.
- `word_count` is a registered value: it reflects words accepted at prior edges only.

## Test plan

1. **Basic fill.** Reset, then feed `word_in` = 0x00000000..0x0000000F on 16 consecutive cycles with `block_ready` = 1.
   - `block_valid` = 1 one cycle after the last accept.
   - `block_out[511:480]` = 0x00000000, `block_out[31:0]` = 0x0000000F.
   - `word_count` sequence 0..15 then 0.
2. **Gapped input.** Feed the same 16 words with `word_valid` toggling every other cycle.
   - Same `block_out` as scenario 1, emitted after 31 cycles.
   - `word_count` holds during gaps.
3. **Backpressure.** Fill block A (0xA0000000 + i) with `block_ready` = 0, then stream block B (0xB0000000 + i).
   - 15 B words accepted; `word_ready` = 0 at `cnt` = 15.
   - `block_out` holds A.
   - Raise `block_ready` for one cycle with B word 15 valid: drain A and load B on the same edge, `block_valid` stays 1, `block_out[31:0]` = 0xB000000F.
4. **Drain only.** With a block held, pulse `block_ready` once while `cnt` = 3.
   - `block_valid` goes to 0 the next cycle.
   - `cnt` unaffected.
5. **Reset mid-block.** Accept 7 words, assert `rst` asynchronously between edges.
   - `word_count`, `block_valid` and `block_out` go to 0 immediately.
   - Feed 16 new words 0x1..0x10: `block_out[511:480]` = 0x00000001, `[31:0]` = 0x00000010, no stale words present.
6. **Back-to-back.** Stream 48 words continuously with `block_ready` = 1.
   - Three blocks emitted, each exactly 16 cycles apart.
   - `word_ready` never drops.
